decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- ID stage of the pipelined RV32I core; consumes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D) and produces the ID/EX pipeline register.
- Contains the architectural register file (write port driven from WB), the main and ALU control decoders, and the immediate extender.
- Supports a FlushE input that inserts a bubble into EX.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RF_DEPTH, 32, number of architectural registers; the address width is 5.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- InstrD  input  32  instruction from IF/ID
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- RegWriteW  input  1  WB write enable
- RDW  input  5  WB destination register
- ResultW  input  32  WB write data
- FlushE  input  1  load a bubble into ID/EX this cycle
- RegWriteE  output  1  register write enable for EX
- ResultSrcE  output  1  1 = load data, 0 = ALU result
- MemWriteE  output  1  store enable
- BranchE  output  1  beq
- ALUSrcE  output  1  1 = immediate operand
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1_E  output  32  rs1 data
- RD2_E  output  32  rs2 data
- Imm_Ext_E  output  32  sign-extended immediate
- RS1_E  output  5  rs1 index
- RS2_E  output  5  rs2 index
- RD_E  output  5  rd index
- PCE  output  32  registered PCD
- PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Reset (rst=0, asynchronous): all ID/EX outputs are 0 and all 32 registers are cleared to 0. Release takes effect on the next rising edge.
- Latency: one cycle. Values present on InstrD/PCD at edge N appear on the *E outputs after edge N.
- Register file:
  - Write on the rising edge when RegWriteW=1 and RDW!=0.
  - x0 always reads 0; writes to x0 are discarded.
  - Reads are combinational with write-first bypass: if RegWriteW=1, RDW!=0 and RDW equals rs1 (or rs2), the read returns ResultW in the same cycle.
- Field extraction: rs1=InstrD[19:15], rs2=InstrD[24:20], rd=InstrD[11:7], op=InstrD[6:0], funct3=InstrD[14:12], funct7b5=InstrD[30].
- Main decoder (outputs RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp):
  - 0000011 lw: 1, I, 1, 0, 1, 0, 00
  - 0100011 sw: 0, S, 1, 1, 0, 0, 00
  - 0110011 R-type: 1, -, 0, 0, 0, 0, 10
  - 0010011 I-ALU: 1, I, 1, 0, 0, 0, 10
  - 1100011 beq: 0, B, 0, 0, 0, 1, 01
  - Any other opcode: all controls 0 (NOP). Data fields still propagate.
- ALU decoder:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 by funct3:
    - 000: sub if op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - other funct3: add
- Immediate extender:
  - I = {{20{i[31]}}, i[31:20]}
  - S = {{20{i[31]}}, i[31:25], i[11:7]}
  - B = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}
  - R-type and unknown opcodes: 0.
- FlushE=1 at an edge: every ID/EX output loads 0 (bubble). The register-file write on that edge still occurs.
- Same-edge WB write and ID read of the same register: ID/EX captures the new value (bypass).
- Reset asserted mid-operation clears the pipeline register and register file immediately, regardless of clk.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random InstrD -> all outputs 0. After release, InstrD=0x00000033 (add x0,x0,x0) -> RD1_E=RD2_E=0, RegWriteE=1, RD_E=0.
- Write x5=0xDEADBEEF (RegWriteW=1, RDW=5), then InstrD=0x00028333 (add x6,x5,x0) -> next cycle RD1_E=0xDEADBEEF, RD2_E=0, RD_E=6, RS1_E=5, ALUControlE=000, ALUSrcE=0, RegWriteE=1.
- InstrD=0xFFC12083 (lw x1,-4(x2)) -> Imm_Ext_E=0xFFFFFFFC, ResultSrcE=1, ALUSrcE=1, RegWriteE=1, MemWriteE=0, RD_E=1. Then InstrD=0x00322423 (sw x3,8(x4)) -> Imm_Ext_E=0x00000008, MemWriteE=1, RegWriteE=0, RS2_E=3.
- Bypass and x0 protection:
  - InstrD reads x5 while RegWriteW=1, RDW=5, ResultW=0x12345678 -> RD1_E=0x12345678.
  - RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF, then read x0 -> 0.
- InstrD=0xFE208CE3 (beq x1,x2,-8) with PCD=0x100 -> Imm_Ext_E=0xFFFFFFF8, BranchE=1, ALUControlE=001, RegWriteE=0, PCE=0x100, PCPlus4E=0x104.
- FlushE=1 with InstrD=0x00028333 and simultaneous write x7=0x55 -> next cycle all *E outputs 0. A following read of x7 returns 0x55.

Source files
------------

// File: rtl/decode_cycle.sv
// ID stage of the RV32I pipeline: register file, main/ALU decoders, immediate
// extender and the ID/EX pipeline register with bubble insertion on FlushE.
module decode_cycle #(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  logic [XLEN-1:0] r_rf [RF_DEPTH];

  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [6:0]      w_op;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  logic            w_reg_write, w_alu_src, w_mem_write, w_result_src, w_branch;
  logic [1:0]      w_imm_src, w_alu_op;
  logic [2:0]      w_alu_ctrl;
  logic [XLEN-1:0] w_imm, w_rd1, w_rd2;

  assign w_rs1      = InstrD[19:15];
  assign w_rs2      = InstrD[24:20];
  assign w_rd       = InstrD[11:7];
  assign w_op       = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7b5 = InstrD[30];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else if (RegWriteW && (RDW != 5'd0)) begin
      r_rf[RDW] <= ResultW;
    end
  end

  // write-first bypass so a same-edge WB result reaches ID/EX
  always_comb begin
    w_rd1 = r_rf[w_rs1];
    w_rd2 = r_rf[w_rs2];
    if (RegWriteW && (RDW == w_rs1)) w_rd1 = ResultW;
    if (RegWriteW && (RDW == w_rs2)) w_rd2 = ResultW;
    if (w_rs1 == 5'd0) w_rd1 = '0;
    if (w_rs2 == 5'd0) w_rd2 = '0;
  end

  // ImmSrc: 00 I, 01 S, 10 B, 11 none (zero)
  always_comb begin
    w_reg_write  = 1'b0;
    w_imm_src    = 2'b11;
    w_alu_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    case (w_op)
      7'b0000011: begin
        w_reg_write = 1'b1; w_imm_src = 2'b00; w_alu_src = 1'b1; w_result_src = 1'b1;
      end
      7'b0100011: begin
        w_imm_src = 2'b01; w_alu_src = 1'b1; w_mem_write = 1'b1;
      end
      7'b0110011: begin
        w_reg_write = 1'b1; w_alu_op = 2'b10;
      end
      7'b0010011: begin
        w_reg_write = 1'b1; w_imm_src = 2'b00; w_alu_src = 1'b1; w_alu_op = 2'b10;
      end
      7'b1100011: begin
        w_imm_src = 2'b10; w_branch = 1'b1; w_alu_op = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctrl = 3'b000;
    case (w_alu_op)
      2'b00: w_alu_ctrl = 3'b000;
      2'b01: w_alu_ctrl = 3'b001;
      default: begin
        case (w_funct3)
          3'b000:  w_alu_ctrl = (w_op[5] && w_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_ctrl = 3'b101;
          3'b110:  w_alu_ctrl = 3'b011;
          3'b111:  w_alu_ctrl = 3'b010;
          default: w_alu_ctrl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_imm_src)
      2'b00:   w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   w_imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: w_imm = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RS1_E       <= 5'd0;
      RS2_E       <= 5'd0;
      RD_E        <= 5'd0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= w_reg_write;
      ResultSrcE  <= w_result_src;
      MemWriteE   <= w_mem_write;
      BranchE     <= w_branch;
      ALUSrcE     <= w_alu_src;
      ALUControlE <= w_alu_ctrl;
      RD1_E       <= w_rd1;
      RD2_E       <= w_rd2;
      Imm_Ext_E   <= w_imm;
      RS1_E       <= w_rs1;
      RS2_E       <= w_rs2;
      RD_E        <= w_rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed cases plus random instructions against a
// behavioural model of the ID stage (register array + instruction semantics).
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RS1_E, RS2_E, RD_E;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [32];

  typedef struct {
    logic        rw, rsrc, mw, br, asrc;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E),
    .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.rw = 0; e.rsrc = 0; e.mw = 0; e.br = 0; e.asrc = 0; e.alu = 0;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.pc4 = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0;
    return e;
  endfunction

  // register value seen by ID, including a same-edge WB write
  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWriteW && RDW == a) return ResultW;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] sext(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 32'(r);
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'd0:    return sub_ok ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   iv, sv, bv;
    e = zero_exp();
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.rd1 = rd_reg(ins[19:15]); e.rd2 = rd_reg(ins[24:20]);
    e.pc = PCD; e.pc4 = PCPlus4D;
    iv = int'(ins[31:20]);
    sv = int'({ins[31:25], ins[11:7]});
    bv = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    case (ins[6:0])
      7'h03: begin e.rw = 1; e.rsrc = 1; e.asrc = 1; e.imm = sext(iv, 12); end
      7'h23: begin e.mw = 1; e.asrc = 1; e.imm = sext(sv, 12); end
      7'h33: begin e.rw = 1; e.alu = alu_of(ins[14:12], ins[30]); end
      7'h13: begin e.rw = 1; e.asrc = 1; e.alu = alu_of(ins[14:12], 1'b0); e.imm = sext(iv, 12); end
      7'h63: begin e.br = 1; e.alu = 3'b001; e.imm = sext(bv, 13); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
    chk("ResultSrcE", 32'(ResultSrcE), 32'(e.rsrc));
    chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
    chk("BranchE", 32'(BranchE), 32'(e.br));
    chk("ALUSrcE", 32'(ALUSrcE), 32'(e.asrc));
    chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
    chk("RD1_E", RD1_E, e.rd1);
    chk("RD2_E", RD2_E, e.rd2);
    chk("Imm_Ext_E", Imm_Ext_E, e.imm);
    chk("RS1_E", 32'(RS1_E), 32'(e.rs1));
    chk("RS2_E", 32'(RS2_E), 32'(e.rs2));
    chk("RD_E", 32'(RD_E), 32'(e.rd));
    chk("PCE", PCE, e.pc);
    chk("PCPlus4E", PCPlus4E, e.pc4);
  endtask

  // one clock: inputs already driven; compare after the edge
  task automatic step();
    exp_t e;
    e = FlushE ? zero_exp() : model(InstrD);
    @(posedge clk);
    #1;
    if (RegWriteW && RDW != 0) m_rf[RDW] = ResultW;
    check_out(e);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = we; RDW = wa; ResultW = wd; FlushE = fl;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  initial begin
    logic [6:0]  opcs [6];
    logic [31:0] ins;
    opcs[0] = 7'h03; opcs[1] = 7'h23; opcs[2] = 7'h33;
    opcs[3] = 7'h13; opcs[4] = 7'h63; opcs[5] = 7'h37;

    clear_model();
    rst = 1'b0;
    drive($urandom, $urandom, 1'b1, 5'd3, $urandom, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      InstrD = $urandom;
      check_out(zero_exp());
    end
    @(negedge clk);
    rst = 1'b1;

    drive(32'h0000_0033, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0); step();
    drive(32'h0000_0000, 32'h4, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0); step();
    drive(32'h0002_8333, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("add_x6_rd1", RD1_E, 32'hDEAD_BEEF);
    drive(32'hFFC1_2083, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("lw_imm", Imm_Ext_E, 32'hFFFF_FFFC);
    drive(32'h0032_2423, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("sw_imm", Imm_Ext_E, 32'h0000_0008);
    drive(32'h0002_8333, 32'h14, 1'b1, 5'd5, 32'h1234_5678, 1'b0); step();
    chk("bypass_rd1", RD1_E, 32'h1234_5678);
    drive(32'h0000_0000, 32'h18, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0); step();
    drive(32'h0000_0333, 32'h1C, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0); step();
    chk("x0_read", RD1_E, 32'd0);
    drive(32'hFE20_8CE3, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("beq_imm", Imm_Ext_E, 32'hFFFF_FFF8);
    chk("beq_pc4", PCPlus4E, 32'h104);
    drive(32'h0002_8333, 32'h104, 1'b1, 5'd7, 32'h55, 1'b1); step();
    chk("flush_rd", 32'(RD_E), 32'd0);
    drive(32'h0003_80B3, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("x7_after_flush", RD1_E, 32'h55);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 5)];
      drive(ins, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? ins[19:15] : 5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 9) == 0));
      step();
      if (n == 200) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        clear_model();
        check_out(zero_exp());
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
